// File: rtl/umips_pkg.sv
// umips data-memory shared definitions: FSM state and access size codes,
// full-word byte-enable constant and the alignment check.
package umips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic misaligned(
    input size_t      sz,
    input logic [1:0] lo
  );
    logic r;
    r = 1'b0;
    unique case (sz)
      SZ_HALF: r = lo[0];
      SZ_WORD: r = |lo;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/umips_dmem_lane.sv
// umips byte-lane steering (store) and lane extract/extend (load).
// Ports: i_st_* store size/offset/data -> o_be/o_wdata; i_ld_* -> o_ld_data.
module umips_dmem_lane
  import umips_pkg::*;
(
  input  size_t       i_st_size,
  input  logic [1:0]  i_st_lo,
  input  logic [31:0] i_wd,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  size_t       i_ld_size,
  input  logic [1:0]  i_ld_lo,
  input  logic        i_ld_sign,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    o_be    = 4'h0;
    o_wdata = i_wd;
    unique case (i_st_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_st_lo;
        o_wdata = {4{i_wd[7:0]}};
      end
      SZ_HALF: begin
        o_be    = i_st_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wd[15:0]}};
      end
      SZ_WORD: o_be = BE_ALL;
      default: o_be = 4'h0;
    endcase
  end

  always_comb begin
    w_b = i_rdata[7:0];
    unique case (i_ld_lo)
      2'd0: w_b = i_rdata[7:0];
      2'd1: w_b = i_rdata[15:8];
      2'd2: w_b = i_rdata[23:16];
      2'd3: w_b = i_rdata[31:24];
      default: w_b = i_rdata[7:0];
    endcase
    w_h = i_ld_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ld_data = i_rdata;
    unique case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{i_ld_sign & w_b[7]}}, w_b};
      SZ_HALF: o_ld_data = {{16{i_ld_sign & w_h[15]}}, w_h};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/umips_dmem_ctrl.sv
// umips M-stage data-memory controller: one req/ack bus transaction per
// load/store, lane steering, load extension, stall, misalign/timeout pulses.
// Ports: M-stage ctrl/data in; stall_m, read_data_w, addr_err, bus_err out;
// dbus_* request side out, dbus_ack/dbus_rdata in.
module umips_dmem_ctrl
  import umips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_m,
  input  logic        mem_to_reg_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] write_data_m,
  input  logic        sign_sel_m,
  input  logic        byte_sel_m,
  input  logic        word_sel_m,
  output logic        stall_m,
  output logic [31:0] read_data_w,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  size_t           r_size;
  logic            r_sign;
  logic [1:0]      r_lo;
  logic [31:0]     r_rdata;
  logic            r_aerr;
  logic            r_berr;

  size_t           w_size;
  logic            w_access;
  logic            w_mis;
  logic            w_go;
  logic            w_to;
  logic            w_stall;
  logic [3:0]      w_st_be;
  logic [31:0]     w_st_wdata;
  logic [31:0]     w_ld_data;

  assign w_access = mem_write_m | mem_to_reg_m;

  always_comb begin
    w_size = SZ_HALF;
    unique case (1'b1)
      word_sel_m:               w_size = SZ_WORD;
      byte_sel_m & ~word_sel_m: w_size = SZ_BYTE;
      default:                  w_size = SZ_HALF;
    endcase
  end

  assign w_mis = misaligned(w_size, alu_out_m[1:0]);
  assign w_go  = w_access & ~w_mis;
  assign w_to  = r_cnt == TO_W'(TIMEOUT - 1);

  umips_dmem_lane u_lane (
    .i_st_size (w_size),
    .i_st_lo   (alu_out_m[1:0]),
    .i_wd      (write_data_m),
    .o_be      (w_st_be),
    .o_wdata   (w_st_wdata),
    .i_ld_size (r_size),
    .i_ld_lo   (r_lo),
    .i_ld_sign (r_sign),
    .i_rdata   (dbus_rdata),
    .o_ld_data (w_ld_data)
  );

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_stall = 1'b1;
          w_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (dbus_ack | w_to) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_size  <= SZ_BYTE;
      r_sign  <= 1'b0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_aerr  <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_aerr <= (r_state == ST_IDLE) & w_access & w_mis;
      r_berr <= 1'b0;
      if (r_state == ST_IDLE && w_go) begin
        r_cnt   <= '0;
        r_we    <= mem_write_m;
        r_addr  <= {alu_out_m[31:2], 2'b00};
        r_wdata <= w_st_wdata;
        r_be    <= w_st_be;
        r_size  <= w_size;
        r_sign  <= sign_sel_m;
        r_lo    <= alu_out_m[1:0];
      end else if (r_state == ST_REQ) begin
        if (dbus_ack) begin
          if (!r_we) r_rdata <= w_ld_data;
        end else if (w_to) begin
          r_berr  <= 1'b1;
          r_rdata <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Gate with rst so a held access cannot stall while reset is applied.
  assign stall_m     = w_stall & ~rst;
  assign dbus_req    = r_state == ST_REQ;
  assign dbus_we     = r_we;
  assign dbus_addr   = r_addr;
  assign dbus_wdata  = r_wdata;
  assign dbus_be     = r_be;
  assign read_data_w = r_rdata;
  assign addr_err    = r_aerr;
  assign bus_err     = r_berr;

endmodule

// File: tb/tb_umips_dmem_ctrl.sv
// Self-checking bench for umips_dmem_ctrl: directed plan plus random
// accesses against an arithmetic reference model of lanes and timing.
module tb_umips_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write_m, mem_to_reg_m;
  logic [31:0] alu_out_m, write_data_m;
  logic        sign_sel_m, byte_sel_m, word_sel_m;
  logic        stall_m;
  logic [31:0] read_data_w;
  logic        addr_err, bus_err;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_rdw;

  always #5 clk = ~clk;

  umips_dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m),
    .sign_sel_m(sign_sel_m), .byte_sel_m(byte_sel_m),
    .word_sel_m(word_sel_m), .stall_m(stall_m),
    .read_data_w(read_data_w), .addr_err(addr_err), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model; sz: 0 byte, 1 half, 2 word.
  function automatic logic [3:0] m_be(int sz, logic [31:0] a);
    int o = int'(a[1:0]);
    if (sz == 0) return 4'(1 << o);
    if (sz == 1) return (o >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(int sz, logic [31:0] wd);
    if (sz == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(int sz, logic [31:0] a,
                                       logic sg, logic [31:0] rd);
    int o = int'(a[1:0]);
    logic [31:0] v;
    if (sz == 0) begin
      v = (rd >> (o * 8)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (rd >> ((o / 2) * 16)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic drive(input logic we, input logic ld, input int sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    mem_write_m  = we;
    mem_to_reg_m = ld;
    byte_sel_m   = (sz == 0);
    word_sel_m   = (sz == 2);
    sign_sel_m   = sg;
    alu_out_m    = a;
    write_data_m = wd;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0, 32'h0);
    dbus_ack = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic access(input logic we, input logic ld, input int sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int waitc, input logic noack,
                        input logic ackall, input int exp_stalls);
    int stalls = 0;
    int reqs = 0;
    int cyc = 0;
    bit fin = 0;
    drive(we, ld, sz, sg, a, wd);
    dbus_ack   = ackall;
    dbus_rdata = rd;
    while (!fin && cyc < 64) begin
      #1;
      cyc++;
      if (stall_m) stalls++;
      if (cyc == 1) chk("stall_idle", {31'b0, stall_m}, 32'd1);
      if (dbus_req) begin
        if (reqs == 0) begin
          chk("addr", dbus_addr, a & ~32'h3);
          chk("be", {28'b0, dbus_be}, {28'b0, m_be(sz, a)});
          chk("we", {31'b0, dbus_we}, {31'b0, we});
          if (we) chk("wdata", dbus_wdata, m_wd(sz, wd));
        end
        dbus_ack = ackall | (!noack && reqs == waitc);
        reqs++;
      end else if (reqs > 0) begin
        if (noack) m_rdw = 32'h0;
        else if (!we) m_rdw = m_ld(sz, a, sg, rd);
        chk("rdata", read_data_w, m_rdw);
        chk("stall_done", {31'b0, stall_m}, 32'd0);
        chk("bus_err", {31'b0, bus_err}, {31'b0, noack});
        chk("req_cycles", reqs, noack ? 16 : waitc + 1);
        chk("cycles", cyc, stalls + 1);
        if (exp_stalls >= 0) chk("stalls", stalls, exp_stalls);
        dbus_ack = ackall;
        fin = 1;
      end
      @(negedge clk);
    end
    if (!fin) chk("access_bound", 32'd0, 32'd1);
    idle_in();
  endtask

  task automatic misal(input logic we, input logic ld, input int sz,
                       input logic [31:0] a);
    drive(we, ld, sz, 1'b0, a, 32'h1234_5678);
    #1;
    chk("mis_stall", {31'b0, stall_m}, 32'd0);
    chk("mis_req0", {31'b0, dbus_req}, 32'd0);
    @(negedge clk);
    idle_in();
    #1;
    chk("mis_aerr", {31'b0, addr_err}, 32'd1);
    chk("mis_req1", {31'b0, dbus_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("mis_aerr_end", {31'b0, addr_err}, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, {31'b0, dbus_req}, 32'd0);
    chk({tag, "_we"}, {31'b0, dbus_we}, 32'd0);
    chk({tag, "_addr"}, dbus_addr, 32'd0);
    chk({tag, "_wdata"}, dbus_wdata, 32'd0);
    chk({tag, "_be"}, {28'b0, dbus_be}, 32'd0);
    chk({tag, "_rdw"}, read_data_w, 32'd0);
    chk({tag, "_aerr"}, {31'b0, addr_err}, 32'd0);
    chk({tag, "_berr"}, {31'b0, bus_err}, 32'd0);
    chk({tag, "_stall"}, {31'b0, stall_m}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd, rd;
    int sz, wt;
    logic we, ld, sg;
    rst = 1'b1;
    idle_in();
    dbus_rdata = 32'h0;
    m_rdw = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // store word, ack first cycle
    access(1, 0, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 2);
    // signed / unsigned byte load, 3 wait cycles
    access(0, 1, 0, 1, 32'h203, 32'h0, 32'h80FF_7F01, 3, 0, 0, 5);
    chk("lb_signed", read_data_w, 32'hFFFF_FF80);
    access(0, 1, 0, 0, 32'h203, 32'h0, 32'h80FF_7F01, 3, 0, 0, 5);
    chk("lb_unsigned", read_data_w, 32'h0000_0080);
    // store half upper lanes, then misaligned half load
    access(1, 0, 1, 0, 32'h12, 32'h0000_ABCD, 32'h0, 0, 0, 0, 2);
    misal(0, 1, 1, 32'h11);
    // load word timeout
    access(0, 1, 2, 0, 32'h400, 32'h0, 32'h0, 0, 1, 0, 17);
    #1;
    chk("berr_end", {31'b0, bus_err}, 32'd0);
    chk("req_end", {31'b0, dbus_req}, 32'd0);
    @(negedge clk);

    // back-to-back with ack always high
    for (int i = 0; i < 6; i++) begin
      sz = $urandom_range(0, 2);
      a  = $urandom;
      if (sz == 1) a = a & ~32'h1;
      if (sz == 2) a = a & ~32'h3;
      we = 1'($urandom_range(0, 1));
      access(we, !we, sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom, 0, 0, 1, 2);
    end
    dbus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_ack_req", {31'b0, dbus_req}, 32'd0);
      chk("late_ack_stall", {31'b0, stall_m}, 32'd0);
      @(negedge clk);
    end
    dbus_ack = 1'b0;

    // reset during second REQ cycle
    drive(0, 1, 2, 0, 32'h300, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_req1", {31'b0, dbus_req}, 32'd1);
    @(negedge clk);
    #1;
    chk("rst_req2", {31'b0, dbus_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_zero("midrst");
    m_rdw = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    access(0, 1, 2, 0, 32'h300, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 3);

    // randomized accesses, some misaligned
    for (int i = 0; i < 40; i++) begin
      sz = $urandom_range(0, 2);
      we = 1'($urandom_range(0, 1));
      ld = !we | 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      rd = $urandom;
      wt = $urandom_range(0, 4);
      a  = $urandom;
      if (sz != 0 && $urandom_range(0, 4) == 0) begin
        if (sz == 1) a = a | 32'h1;
        else a = (a & ~32'h3) | 32'($urandom_range(1, 3));
        misal(we, ld, sz, a);
      end else begin
        if (sz == 1) a = a & ~32'h1;
        if (sz == 2) a = a & ~32'h3;
        access(we, ld, sz, sg, a, wd, rd, wt, 0, 0, wt + 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
